// File: rtl/mis_stimulus_gen.sv
// Launch/capture engine for multiple-input-switching delay characterisation of a NOR/inverter chain.
// Optional delta_b sweep (cfg_sweep_n / sweep_last ports) is compiled in with `define MIS_SWEEP_EN.
module mis_stimulus_gen #(
  parameter int CNT_W       = 8,
  parameter int LAT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cfg_dir,
  input  logic [CNT_W-1:0] cfg_delta_a,
  input  logic [CNT_W-1:0] cfg_delta_b,
`ifdef MIS_SWEEP_EN
  input  logic [CNT_W-1:0] cfg_sweep_n,
  output logic             sweep_last,
`endif
  output logic             stim_a1,
  output logic             stim_a2,
  input  logic             resp_in,
  output logic             busy,
  output logic             done,
  output logic [LAT_W-1:0] lat_out,
  output logic             timeout
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_LAUNCH, S_RESTORE} state_e;

  localparam int CMP_W = (CNT_W > LAT_W) ? CNT_W : LAT_W;
  localparam int PRE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

  state_e state_q, state_d;
  logic dir_q, dir_d;
  logic [CNT_W-1:0] da_q, da_d;
  logic [CNT_W-1:0] db_q, db_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic sw_a_q, sw_a_d;
  logic sw_b_q, sw_b_d;
  logic det_q, det_d;
  logic [LAT_W-1:0] lat_cap_q, lat_cap_d;
  logic stim_a1_q, stim_a1_d;
  logic stim_a2_q, stim_a2_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [LAT_W-1:0] lat_out_q, lat_out_d;
  logic timeout_q, timeout_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  logic tgt;
  logic at_max;
  logic hit;
  logic last_iter;

`ifdef MIS_SWEEP_EN
  logic [CNT_W-1:0] sweep_n_q, sweep_n_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic sweep_last_q, sweep_last_d;
  assign last_iter  = (iter_q == sweep_n_q);
  assign sweep_last = sweep_last_q;
`else
  assign last_iter = 1'b1;
`endif

  // Target level is the opposite of the pre-launch level; resp is only trusted after synchronising.
  assign tgt    = ~dir_q;
  assign at_max = (lat_cnt_q == LAT_MAX);
  assign hit    = (sync_q[SYNC_STAGES-1] == tgt);

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], resp_in};

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    da_d      = da_q;
    db_d      = db_q;
    pre_cnt_d = pre_cnt_q;
    lat_cnt_d = lat_cnt_q;
    sw_a_d    = sw_a_q;
    sw_b_d    = sw_b_q;
    det_d     = det_q;
    lat_cap_d = lat_cap_q;
    stim_a1_d = stim_a1_q;
    stim_a2_d = stim_a2_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lat_out_d = lat_out_q;
    timeout_d = timeout_q;
`ifdef MIS_SWEEP_EN
    sweep_n_d    = sweep_n_q;
    iter_d       = iter_q;
    sweep_last_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        stim_a1_d = 1'b0;
        stim_a2_d = 1'b0;
        if (start) begin
          dir_d     = cfg_dir;
          da_d      = cfg_delta_a;
          db_d      = cfg_delta_b;
          busy_d    = 1'b1;
          pre_cnt_d = '0;
          stim_a1_d = cfg_dir;
          stim_a2_d = cfg_dir;
          state_d   = S_PRE;
`ifdef MIS_SWEEP_EN
          sweep_n_d = cfg_sweep_n;
          iter_d    = '0;
`endif
        end
      end
      S_PRE: begin
        if (pre_cnt_q == PRE_W'(SETTLE - 1)) begin
          lat_cnt_d = '0;
          sw_a_d    = 1'b0;
          sw_b_d    = 1'b0;
          det_d     = 1'b0;
          state_d   = S_LAUNCH;
        end else begin
          pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
      end
      S_LAUNCH: begin
        if (!at_max) lat_cnt_d = lat_cnt_q + LAT_W'(1);
        // A delta beyond the counter range is forced through once the counter saturates.
        if (!sw_a_q && ((CMP_W'(lat_cnt_q) == CMP_W'(da_q)) || at_max)) begin
          sw_a_d    = 1'b1;
          stim_a1_d = tgt;
        end
        if (!sw_b_q && ((CMP_W'(lat_cnt_q) == CMP_W'(db_q)) || at_max)) begin
          sw_b_d    = 1'b1;
          stim_a2_d = tgt;
        end
        if (hit && !det_q) begin
          det_d     = 1'b1;
          lat_cap_d = lat_cnt_q;
        end
        if (sw_a_q && sw_b_q && (det_q || hit || at_max)) begin
          stim_a1_d = 1'b0;
          stim_a2_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = !last_iter;
          lat_out_d = det_q ? lat_cap_q : (hit ? lat_cnt_q : LAT_MAX);
          timeout_d = !(det_q || hit);
          state_d   = S_RESTORE;
`ifdef MIS_SWEEP_EN
          sweep_last_d = last_iter;
`endif
        end
      end
      S_RESTORE: begin
        state_d = S_IDLE;
`ifdef MIS_SWEEP_EN
        if (!last_iter) begin
          iter_d    = iter_q + CNT_W'(1);
          db_d      = db_q + CNT_W'(1);
          pre_cnt_d = '0;
          stim_a1_d = dir_q;
          stim_a2_d = dir_q;
          state_d   = S_PRE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      da_q      <= '0;
      db_q      <= '0;
      pre_cnt_q <= '0;
      lat_cnt_q <= '0;
      sw_a_q    <= 1'b0;
      sw_b_q    <= 1'b0;
      det_q     <= 1'b0;
      lat_cap_q <= '0;
      stim_a1_q <= 1'b0;
      stim_a2_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lat_out_q <= '0;
      timeout_q <= 1'b0;
      sync_q    <= '0;
`ifdef MIS_SWEEP_EN
      sweep_n_q    <= '0;
      iter_q       <= '0;
      sweep_last_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      da_q      <= da_d;
      db_q      <= db_d;
      pre_cnt_q <= pre_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      sw_a_q    <= sw_a_d;
      sw_b_q    <= sw_b_d;
      det_q     <= det_d;
      lat_cap_q <= lat_cap_d;
      stim_a1_q <= stim_a1_d;
      stim_a2_q <= stim_a2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lat_out_q <= lat_out_d;
      timeout_q <= timeout_d;
      sync_q    <= sync_d;
`ifdef MIS_SWEEP_EN
      sweep_n_q    <= sweep_n_d;
      iter_q       <= iter_d;
      sweep_last_q <= sweep_last_d;
`endif
    end
  end

  assign stim_a1 = stim_a1_q;
  assign stim_a2 = stim_a2_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign lat_out = lat_out_q;
  assign timeout = timeout_q;

endmodule
